// File: rtl/host_mem_responder.sv
// Host-side memory responder: line-wide backing store answering read/write go requests
// with programmable latency. Optional HOST_MEM_RESP_STATS_EN adds handshake counters.
module host_mem_responder #(
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned DEPTH_LINES   = 256,
  parameter int unsigned RD_LATENCY    = 4,
  parameter int unsigned WR_LATENCY    = 2,
  parameter int unsigned INIT_CYCLES   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_rgo,
  input  logic                     host_wgo,
  input  logic                     host_re,
  input  logic                     host_we,
  input  logic [ADDR_BITCOUNT-1:0] address,
  input  logic [CL_SIZE_WIDTH-1:0] host_wdata,
  output logic [CL_SIZE_WIDTH-1:0] host_rdata,
  output logic                     host_init,
  output logic                     host_rd_ready,
  output logic                     host_wr_ready,
  output logic                     addr_err,
  output logic                     proto_err
`ifdef HOST_MEM_RESP_STATS_EN
  ,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
`endif
);

  localparam int unsigned LINE_SHIFT = $clog2(CL_SIZE_WIDTH / 8);
  localparam int unsigned IDX_W      = $clog2(DEPTH_LINES);
  localparam int unsigned LAT_MAX    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_MAX    = (LAT_MAX > INIT_CYCLES) ? LAT_MAX : INIT_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    STARTUP = 3'd0,
    IDLE    = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_WAIT = 3'd4,
    WR_RESP = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic                     rd_oor_q, rd_oor_d;
  logic [CL_SIZE_WIDTH-1:0] rdata_q, rdata_d;
  logic                     init_q, init_d;
  logic                     rd_ready_q, rd_ready_d;
  logic                     wr_ready_q, wr_ready_d;
  logic                     addr_err_q, addr_err_d;
  logic                     proto_err_q, proto_err_d;

  logic [IDX_W-1:0]         addr_idx_c;
  logic                     addr_oor_c;
  logic                     mem_we_c;
  logic                     unused_addr_c;

  // Backing store: intentionally not reset, contents survive rst_n.
  logic [CL_SIZE_WIDTH-1:0] store_mem [DEPTH_LINES];

  // Line index decode; upper address bits must be zero for an in-range line.
  assign addr_idx_c    = address[LINE_SHIFT +: IDX_W];
  assign addr_oor_c    = |address[ADDR_BITCOUNT-1:LINE_SHIFT+IDX_W];
  assign unused_addr_c = ^address[LINE_SHIFT-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    rd_oor_d    = rd_oor_q;
    rdata_d     = rdata_q;
    init_d      = init_q;
    rd_ready_d  = rd_ready_q;
    wr_ready_d  = wr_ready_q;
    addr_err_d  = 1'b0;
    proto_err_d = 1'b0;
    mem_we_c    = 1'b0;

    // Strobes arriving outside their response phase are ignored and flagged.
    if (host_re && (state_q != RD_RESP)) proto_err_d = 1'b1;
    if (host_we && (state_q != WR_RESP)) proto_err_d = 1'b1;

    case (state_q)
      STARTUP: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          init_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (host_rgo) begin
          rd_idx_d = addr_idx_c;
          rd_oor_d = addr_oor_c;
          cnt_d    = '0;
          state_d  = RD_WAIT;
          if (host_wgo) proto_err_d = 1'b1;
        end else if (host_wgo) begin
          cnt_d   = '0;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (!host_rgo) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          rdata_d    = rd_oor_q ? '0 : store_mem[rd_idx_q];
          addr_err_d = rd_oor_q;
          rd_ready_d = 1'b1;
          state_d    = RD_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (host_re) begin
          rd_ready_d = 1'b0;
          state_d    = IDLE;
        end
      end
      WR_WAIT: begin
        if (!host_wgo) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WR_LATENCY - 1)) begin
          wr_ready_d = 1'b1;
          state_d    = WR_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_RESP: begin
        // Write address is taken at host_we; the controller settles it late.
        if (host_we) begin
          wr_ready_d = 1'b0;
          state_d    = IDLE;
          if (addr_oor_c) addr_err_d = 1'b1;
          else            mem_we_c   = 1'b1;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STARTUP;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      rd_oor_q    <= 1'b0;
      rdata_q     <= '0;
      init_q      <= 1'b0;
      rd_ready_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      rd_oor_q    <= rd_oor_d;
      rdata_q     <= rdata_d;
      init_q      <= init_d;
      rd_ready_q  <= rd_ready_d;
      wr_ready_q  <= wr_ready_d;
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) store_mem[addr_idx_c] <= host_wdata;
  end

  assign host_rdata    = rdata_q;
  assign host_init     = init_q;
  assign host_rd_ready = rd_ready_q;
  assign host_wr_ready = wr_ready_q;
  assign addr_err      = addr_err_q;
  assign proto_err     = proto_err_q;

`ifdef HOST_MEM_RESP_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Completed handshakes, including out-of-range ones; aborts never reach here.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if ((state_q == RD_RESP) && host_re) rd_count_d = rd_count_q + 32'd1;
    if ((state_q == WR_RESP) && host_we) wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder with default parameters.
module tb_host_mem_responder;
  localparam int unsigned CLW = 512;
  localparam int unsigned AW  = 64;

  logic           clk;
  logic           rst_n;
  logic           host_rgo, host_wgo, host_re, host_we;
  logic [AW-1:0]  address;
  logic [CLW-1:0] host_wdata, host_rdata;
  logic           host_init, host_rd_ready, host_wr_ready, addr_err, proto_err;
`ifdef HOST_MEM_RESP_STATS_EN
  logic [31:0]    rd_count, wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [CLW-1:0] pat_a5, pat_0, pat_c3, pat_p1, pat_p2, pat_x;

  host_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_rgo      (host_rgo),
    .host_wgo      (host_wgo),
    .host_re       (host_re),
    .host_we       (host_we),
    .address       (address),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .host_init     (host_init),
    .host_rd_ready (host_rd_ready),
    .host_wr_ready (host_wr_ready),
    .addr_err      (addr_err),
    .proto_err     (proto_err)
`ifdef HOST_MEM_RESP_STATS_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a write; returns cycles from accept to wr_ready and the addr_err seen after host_we.
  task automatic do_write(input logic [AW-1:0] a, input logic [CLW-1:0] d,
                          output int lat, output bit aerr);
    address  = a;
    host_wgo = 1'b1;
    lat      = 0;
    aerr     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (host_wr_ready) begin
        lat = i;
        break;
      end
    end
    host_wgo = 1'b0;
    if (lat != 0) begin
      host_wdata = d;
      host_we    = 1'b1;
      tick();
      host_we = 1'b0;
      aerr    = addr_err;
    end
  endtask

  // Issues a read; returns data, latency, addr_err at data return, and rd_ready after host_re.
  task automatic do_read(input logic [AW-1:0] a, output logic [CLW-1:0] d, output int lat,
                         output bit aerr, output bit rdy_after);
    address  = a;
    host_rgo = 1'b1;
    lat      = 0;
    d        = '0;
    aerr     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (host_rd_ready) begin
        lat  = i;
        d    = host_rdata;
        aerr = addr_err;
        break;
      end
    end
    host_rgo = 1'b0;
    if (lat != 0) begin
      host_re = 1'b1;
      tick();
      host_re = 1'b0;
    end
    rdy_after = host_rd_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_rgo = 1'b0; host_wgo = 1'b0; host_re = 1'b0; host_we = 1'b0;
    address = '0; host_wdata = '0;
    repeat (3) tick();
    checks++;
    if ({host_init, host_rd_ready, host_wr_ready, addr_err, proto_err} !== 5'b0 ||
        host_rdata !== '0) begin
      errors++;
      $display("FAIL reset_vals: got %b rdata %0h expected 00000 rdata 0",
               {host_init, host_rd_ready, host_wr_ready, addr_err, proto_err}, host_rdata);
    end
    host_rgo = 1'b1;
    rst_n    = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++;
      if (host_init !== 1'b0 || host_rd_ready !== 1'b0) begin
        errors++;
        $display("FAIL startup_cycle%0d: got init %b rdy %b expected 0 0", n, host_init, host_rd_ready);
      end
    end
    host_rgo = 1'b0;
    tick();
    checks++;
    if (host_init !== 1'b1) begin
      errors++;
      $display("FAIL init_cycle8: got %b expected 1", host_init);
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (host_rd_ready !== 1'b0 || host_init !== 1'b1) begin
        errors++;
        $display("FAIL startup_rgo_ignored: got rdy %b init %b expected 0 1", host_rd_ready, host_init);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; bit aerr, rdy;
    logic [CLW-1:0] d;
    do_write(64'h0, pat_0, lat, aerr);
    do_write(64'h40, pat_a5, lat, aerr);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++;
    if (aerr !== 1'b0) begin errors++; $display("FAIL wr_addr_err: got %b expected 0", aerr); end
    checks++;
    if (host_wr_ready !== 1'b0) begin
      errors++; $display("FAIL wr_ready_drop: got %b expected 0", host_wr_ready);
    end
    do_read(64'h40, d, lat, aerr, rdy);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL rd_latency: got %0d expected 5", lat); end
    checks++;
    if (d !== pat_a5) begin errors++; $display("FAIL rd_data: got %0h expected %0h", d, pat_a5); end
    checks++;
    if (aerr !== 1'b0 || rdy !== 1'b0) begin
      errors++; $display("FAIL rd_end: got aerr %b rdy %b expected 0 0", aerr, rdy);
    end
  endtask

  task automatic test_out_of_range();
    int lat; bit aerr, rdy;
    logic [CLW-1:0] d;
    do_read(64'd256 << 6, d, lat, aerr, rdy);
    checks++;
    if (lat !== 5 || d !== '0 || aerr !== 1'b1) begin
      errors++; $display("FAIL oor_read: got lat %0d aerr %b data %0h expected 5 1 0", lat, aerr, d);
    end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_pulse_len: got %b expected 0", addr_err); end
    do_write(64'd256 << 6, pat_x, lat, aerr);
    checks++;
    if (lat !== 3 || aerr !== 1'b1) begin
      errors++; $display("FAIL oor_write: got lat %0d aerr %b expected 3 1", lat, aerr);
    end
    do_read(64'h0, d, lat, aerr, rdy);
    checks++;
    if (d !== pat_0 || aerr !== 1'b0) begin
      errors++; $display("FAIL oor_line0_intact: got %0h expected %0h", d, pat_0);
    end
    do_read(64'h8000_0000_0000_0040, d, lat, aerr, rdy);
    checks++;
    if (d !== '0 || aerr !== 1'b1) begin
      errors++; $display("FAIL oor_high_bit: got aerr %b data %0h expected 1 0", aerr, d);
    end
  endtask

  task automatic test_proto_err();
    int lat; bit aerr, rdy, wr_seen;
    logic [CLW-1:0] d;
    address  = 64'h40;
    host_rgo = 1'b1;
    host_wgo = 1'b1;
    tick();
    host_wgo = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_both: got %b expected 1", proto_err); end
    lat = 0; d = '0; wr_seen = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (host_wr_ready) wr_seen = 1'b1;
      if (host_rd_ready) begin
        lat = i; d = host_rdata;
        break;
      end
    end
    host_rgo = 1'b0;
    host_re  = 1'b1;
    tick();
    host_re = 1'b0;
    checks++;
    if (lat !== 5 || d !== pat_a5 || wr_seen !== 1'b0) begin
      errors++; $display("FAIL proto_read_wins: got lat %0d wr %b data %0h expected 5 0 %0h", lat, wr_seen, d, pat_a5);
    end
    host_wdata = '1;
    host_we    = 1'b1;
    tick();
    host_we = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_we_idle: got %b expected 1", proto_err); end
    tick();
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_pulse_len: got %b expected 0", proto_err); end
    do_read(64'h40, d, lat, aerr, rdy);
    checks++;
    if (d !== pat_a5) begin errors++; $display("FAIL proto_no_write: got %0h expected %0h", d, pat_a5); end
  endtask

  task automatic test_abort();
    int lat; bit aerr, rdy, seen;
    logic [CLW-1:0] d;
    address  = 64'h80;
    host_rgo = 1'b1;
    tick();
    tick();
    host_rgo = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (host_rd_ready || proto_err || addr_err) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b expected 0", seen); end
    do_write(64'h80, pat_c3, lat, aerr);
    checks++;
    if (lat !== 3 || aerr !== 1'b0) begin
      errors++; $display("FAIL abort_then_write: got lat %0d aerr %b expected 3 0", lat, aerr);
    end
    do_read(64'h80, d, lat, aerr, rdy);
    checks++;
    if (d !== pat_c3) begin errors++; $display("FAIL abort_readback: got %0h expected %0h", d, pat_c3); end
  endtask

  task automatic test_reset_mid_write();
    int lat; bit aerr, rdy;
    logic [CLW-1:0] d;
    do_write(64'hC0, pat_p1, lat, aerr);
    address  = 64'hC0;
    host_wgo = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (host_wr_ready) begin lat = i; break; end
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rstmid_wr_latency: got %0d expected 3", lat); end
    host_wdata = pat_p2;
    host_we    = 1'b1;
    rst_n      = 1'b0;
    #1;
    checks++;
    if ({host_init, host_rd_ready, host_wr_ready, addr_err, proto_err} !== 5'b0 ||
        host_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b rdata %0h expected 00000 rdata 0",
               {host_init, host_rd_ready, host_wr_ready, addr_err, proto_err}, host_rdata);
    end
    tick();
    tick();
    host_we  = 1'b0;
    host_wgo = 1'b0;
    rst_n    = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (host_init) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL rstmid_init: got %0d expected 8", lat); end
    do_read(64'hC0, d, lat, aerr, rdy);
    checks++;
    if (d !== pat_p1) begin errors++; $display("FAIL rstmid_line_kept: got %0h expected %0h", d, pat_p1); end
  endtask

`ifdef HOST_MEM_RESP_STATS_EN
  task automatic test_stats();
    int lat; bit aerr, rdy;
    logic [CLW-1:0] d;
    do_write(64'h100, pat_a5, lat, aerr);
    do_write(64'h140, pat_c3, lat, aerr);
    do_read(64'h100, d, lat, aerr, rdy);
    do_read(64'h140, d, lat, aerr, rdy);
    checks++;
    if (rd_count !== 32'd3 || wr_count !== 32'd2) begin
      errors++; $display("FAIL stats_counts: got rd %0d wr %0d expected 3 2", rd_count, wr_count);
    end
  endtask
`endif

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_0  = {16{32'hDEAD_BEEF}};
    pat_c3 = {64{8'hC3}};
    pat_p1 = {8{64'h0123_4567_89AB_CDEF}};
    pat_p2 = {8{64'hFEDC_BA98_7654_3210}};
    pat_x  = {32{16'h5A5A}};
    test_reset();
    test_write_read();
    test_out_of_range();
    test_proto_err();
    test_abort();
    test_reset_mid_write();
`ifdef HOST_MEM_RESP_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/host_mem_responder.md
# host_mem_responder

Host-side responder for the memory controller's host interface. It answers read-go and write-go requests against a line-wide backing store with programmable latency, and asserts host_init after a startup delay. Read data is returned on the host read bus; write data is accepted from the host write bus. The block sits opposite the memory controller in integration and system simulation, standing in for the host DMA/FIFO layer.

## Interface
- CL_SIZE_WIDTH, 512: line width in bits; one transfer moves one line.
- ADDR_BITCOUNT, 64: byte address width.
- DEPTH_LINES, 256: backing-store lines; power of two, ≥2.
- RD_LATENCY, 4: cycles from read accept to host_rd_ready; ≥1.
- WR_LATENCY, 2: cycles from write accept to host_wr_ready; ≥1.
- INIT_CYCLES, 8: cycles after reset release before host_init; ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- host_rgo  in  1  read request, level, from controller.
- host_wgo  in  1  write request, level, from controller.
- host_re  in  1  read-data consume strobe.
- host_we  in  1  write-data commit strobe.
- address  in  ADDR_BITCOUNT  byte address (controller's corrected_address).
- host_wdata  in  CL_SIZE_WIDTH  write line from controller.
- host_rdata  out  CL_SIZE_WIDTH  read line to controller.
- host_init  out  1  responder initialised; sticky until reset.
- host_rd_ready  out  1  read data valid on host_rdata.
- host_wr_ready  out  1  responder will accept host_we.
- addr_err  out  1  one-cycle pulse: line index ≥ DEPTH_LINES.
- proto_err  out  1  one-cycle pulse: protocol violation.

## Operation
- LINE_SHIFT = log2(CL_SIZE_WIDTH/8); line index = address >> LINE_SHIFT. Out of range if index ≥ DEPTH_LINES (upper bits checked, no wrap).
- States: STARTUP, IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- STARTUP: counter counts INIT_CYCLES, then host_init=1 and go to IDLE. Requests are ignored in STARTUP.
- IDLE: host_rgo → latch index, load latency counter, go to RD_WAIT. Otherwise host_wgo → go to WR_WAIT. If both are high, read wins and proto_err pulses.
- RD_WAIT: count RD_LATENCY cycles. On the last cycle, register mem[index] (zero if out of range, with an addr_err pulse) into host_rdata and go to RD_RESP. If host_rgo drops in RD_WAIT → abort to IDLE, no error.
- RD_RESP: host_rd_ready=1, host_rdata held stable. host_re high → IDLE. host_rgo may be low here; completion is keyed only on host_re.
- WR_WAIT: count WR_LATENCY cycles, then go to WR_RESP. If host_wgo drops → abort to IDLE.
- WR_RESP: host_wr_ready=1. host_we high → write host_wdata to mem[index of address sampled this cycle], then IDLE. An out-of-range write is dropped and pulses addr_err. The write address is sampled at host_we, not at request, because the controller settles the address during its bubble cycle.
- host_re outside RD_RESP, or host_we outside WR_RESP: ignored, proto_err pulses.
- Single outstanding transaction; no pipelining.
- Backing store is not reset; contents are undefined until written.

## Timing
- Reset values: host_init=0, host_rd_ready=0, host_wr_ready=0, host_rdata=0, addr_err=0, proto_err=0, state=STARTUP.
- rst_n release before edge 0: host_init is high after edge INIT_CYCLES-1, i.e. visible in cycle INIT_CYCLES.
- Read: host_rgo sampled high at edge t → host_rd_ready high from cycle t+RD_LATENCY+1 until the edge sampling host_re, then low the next cycle.
- Write: host_wgo sampled at edge t → host_wr_ready high from cycle t+WR_LATENCY+1. The store updates at the edge sampling host_we; host_wr_ready is low the following cycle.
- Back-to-back: a new request is accepted at the earliest in the cycle after return to IDLE.
- Reset mid-transaction: immediate return to STARTUP, all outputs to reset values. Store contents are kept, and a pending write is lost.

## Configuration
- HOST_MEM_RESP_STATS_EN defined: adds outputs rd_count and wr_count (32 bits each, reset 0, wrapping). They increment on each completed host_re or host_we handshake, including out-of-range handshakes; aborts are not counted.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset release with defaults → host_init low for cycles 0–7, high from cycle 8; an rgo in STARTUP gets no response.
- Write 0xA5-pattern to address 0x40, then read 0x40 → wr_ready 3 cycles after wgo; rd_ready 5 cycles after rgo with host_rdata = 0xA5-pattern.
- Read address 256<<6 → rdata=0 with one addr_err pulse. Write to that address → addr_err, and the store is unchanged (line 0 reread intact).
- rgo and wgo high together in IDLE → proto_err pulse, read path taken. host_we while idle → proto_err, no store write.
- rgo dropped in RD_WAIT cycle 2 → return to IDLE, rd_ready never rises. A following write completes normally.
- rst_n asserted in WR_RESP → outputs reset immediately and the line is not written. With STATS_EN, 3 reads and 2 writes give rd_count=3, wr_count=2.
